muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle datapath.
//   Executes MULTU/MULT/DIVU/DIV on two WIDTH-bit operands at one bit per cycle.
//   Uses a start/busy/done handshake; the controller stalls on busy before reading HI/LO.
//   Supports direct HI/LO writes (MTHI/MTLO) and abort of an in-flight operation.
// PARAMETERS
//   WIDTH   32   operand, HI and LO width; legal values are even and >= 4.
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low reset
//   start     in   1      launch operation; sampled only when busy=0
//   op        in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
//   src_a     in   WIDTH  multiplicand or dividend; sampled with start
//   src_b     in   WIDTH  multiplier or divisor; sampled with start
//   abort     in   1      cancel the in-flight operation
//   hi_we     in   1      write wdata to HI (MTHI)
//   lo_we     in   1      write wdata to LO (MTLO)
//   wdata     in   WIDTH  HI/LO write data
//   busy      out  1      operation in flight
//   done      out  1      one-cycle pulse when HI/LO receive a result
//   div_zero  out  1      last DIV/DIVU had divisor 0; sticky until next accepted start
//   hi        out  WIDTH  HI register (product upper half / remainder)
//   lo        out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//   Reset (reset=0, async): state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0.
//     Takes effect immediately, including mid-operation; any partial result is discarded.
//   States:
//     IDLE  -> RUN on start=1.
//     RUN   WIDTH cycles -> FIXUP.
//     FIXUP one cycle -> IDLE.
//   Start acceptance (edge E0, start=1 in IDLE):
//     Latch op; latch |src_a|, |src_b| for signed ops, raw values otherwise.
//     Latch result sign: MULT uses a^b sign bits; DIV quotient uses a^b, DIV remainder uses sign of a.
//     Clear div_zero; busy=1 after E0.
//   RUN (one step per cycle):
//     Multiply: shift-add, producing a 2*WIDTH-bit unsigned product.
//     Divide: restoring division, one quotient bit per cycle.
//     Internal iteration counter is $clog2(WIDTH+1) bits.
//   FIXUP, completing at edge E(WIDTH+1):
//     Negate the product, quotient or remainder as required (two's complement, WIDTH bits, wraps).
//     Write hi/lo; busy=0 and done=1 for exactly one cycle after this edge.
//     Latency: done is visible WIDTH+1 cycles after the start edge.
//   Divide by zero (src_b=0): full latency is still taken; lo = all ones, hi = original src_a, div_zero=1.
//   DIV of MIN by -1: lo = MIN, hi = 0; no flag.
//   start while busy=1: ignored; no queuing, operands not re-sampled.
//   abort=1 while busy=1:
//     Next edge returns to IDLE; busy=0, done stays 0, hi/lo unchanged.
//     abort in IDLE is a no-op; abort has priority over a same-cycle start.
//   hi_we/lo_we:
//     Honoured only when busy=0.
//     Ignored while busy=1, including the FIXUP cycle (result wins).
//     hi_we with start in the same IDLE cycle: write lands, then the operation starts.
//   hi/lo keep their previous values throughout RUN and change only at FIXUP, on a direct write, or on reset.
// TESTING  (WIDTH=32 unless stated)
//   MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at start+33 cycles; hi=0xFFFFFFFE, lo=0x00000001.
//   MULT a=-7 b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   DIVU a=100 b=7 -> lo=14, hi=2.
//   DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
//   DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_zero=1.
//     Next MULTU start clears div_zero.
//   start during RUN with different operands -> ignored; the original result is written.
//   hi_we during busy -> ignored; hi_we in IDLE -> hi=wdata next cycle.
//   abort at RUN cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged.
//   reset low at RUN cycle 10 -> all outputs 0 immediately.
//   Recovery after abort/reset: new op completes correctly.
//   WIDTH=8 random regression of all ops vs. reference model -> done after 9 cycles, results match.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit with HI/LO registers.
// Start/busy/done handshake, direct HI/LO writes and abort support.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0] quo_f, rem_f;

  always_comb begin
    accept = (state_q == IDLE) && start && !abort;
    mag_a  = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b  = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;
    sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    // remainder stays below the divisor, so a WIDTH-bit difference is exact
    rsh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge     = rsh >= {1'b0, mcand_q};
    diff   = rsh[WIDTH-1:0] - mcand_q;
    prod   = {acc_hi_q, acc_lo_q};
    prod_f = neg_q_q ? -prod : prod;
    quo_f  = neg_q_q ? -acc_lo_q : acc_lo_q;
    rem_f  = neg_r_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    dz_d       = dz_q;
    mcand_d    = mcand_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (accept) begin
          state_d    = RUN;
          cnt_d      = '0;
          is_div_d   = op[1];
          neg_q_d    = op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_r_d    = op[0] & src_a[WIDTH-1];
          dz_d       = op[1] & (src_b == '0);
          mcand_d    = mag_b;
          acc_hi_d   = '0;
          acc_lo_d   = mag_a;
          div_zero_d = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_hi_d = ge ? diff : rsh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ge};
          end else begin
            acc_hi_d = sum[WIDTH:1];
            acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = FIXUP;
        end
      end
      FIXUP: begin
        state_d = IDLE;
        if (!abort) begin
          done_d     = 1'b1;
          div_zero_d = dz_q;
          if (!is_div_q) begin
            hi_d = prod_f[2*WIDTH-1:WIDTH];
            lo_d = prod_f[WIDTH-1:0];
          end else begin
            // divide by zero: remainder fix-up restores the original dividend
            hi_d = rem_f;
            lo_d = dz_q ? '1 : quo_f;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_q       <= 1'b0;
      mcand_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      dz_q       <= dz_d;
      mcand_q    <= mcand_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) plus a WIDTH=8 model sweep.
// Immediate assertions count and report each failed comparison.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8, abort8, hi_we8, lo_we8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;
  int elapsed = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .abort(abort),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .op(op8),
    .src_a(a8), .src_b(b8), .abort(abort8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .div_zero(dz8),
    .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    elapsed++;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    elapsed = 0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] eh,
                           input logic [31:0] el);
    while (!done && elapsed < 40) tick();
    check({tag, "_latency"}, elapsed, 33);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  function automatic logic [15:0] ref8(input logic [1:0] o,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    int sa, sb, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin p = a * b; return p[15:0]; end
      2'b01: begin p = sa * sb; return p[15:0]; end
      2'b10: begin
        if (b == 0) return {a, 8'hFF};
        q = a / b; r = a % b;
        return {r[7:0], q[7:0]};
      end
      default: begin
        if (b == 0) return {a, 8'hFF};
        if (sa == -128 && sb == -1) return 16'h0080;
        q = sa / sb; r = sa % sb;
        return {r[7:0], q[7:0]};
      end
    endcase
  endfunction

  initial begin
    logic seen;
    logic [15:0] e8;
    int n8;
    rst_n = 1'b0;
    start = 0; abort = 0; hi_we = 0; lo_we = 0;
    op = 0; src_a = 0; src_b = 0; wdata = 0;
    start8 = 0; abort8 = 0; hi_we8 = 0; lo_we8 = 0;
    op8 = 0; a8 = 0; b8 = 0; wdata8 = 0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst_n = 1'b1;
    tick();

    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("run_hi_hold", hi, 0);
    wait_done("multu_max", 32'hFFFFFFFE, 32'h00000001);
    launch(2'b01, -32'sd7, 32'd3);
    wait_done("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB);
    launch(2'b11, -32'sd7, 32'd2);
    wait_done("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    launch(2'b10, 32'd100, 32'd7);
    wait_done("divu", 32'd2, 32'd14);
    check("dz_clear", div_zero, 0);
    launch(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 32'h0, 32'h80000000);
    check("ovf_noflag", div_zero, 0);
    launch(2'b10, 32'd5, 32'd0);
    wait_done("divu_zero", 32'd5, 32'hFFFFFFFF);
    check("dz_set", div_zero, 1);
    launch(2'b11, -32'sd9, 32'd0);
    wait_done("div_zero_neg", 32'hFFFFFFF7, 32'hFFFFFFFF);
    check("dz_set2", div_zero, 1);
    launch(2'b00, 32'd3, 32'd4);
    check("dz_cleared_on_start", div_zero, 0);
    wait_done("multu_small", 32'd0, 32'd12);

    launch(2'b00, 32'd6, 32'd7);
    repeat (5) tick();
    op = 2'b10; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("start_ignored", 32'd0, 32'd42);

    launch(2'b00, 32'd2, 32'd3);
    repeat (3) tick();
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("we_busy_hi", hi, 0);
    check("we_busy_lo", lo, 42);
    wait_done("we_busy_res", 32'd0, 32'd6);
    hi_we = 1'b1; wdata = 32'hCAFE0001;
    tick();
    hi_we = 1'b0;
    check("mthi", hi, 32'hCAFE0001);
    check("mthi_lo_kept", lo, 6);
    lo_we = 1'b1; wdata = 32'h00000055;
    tick();
    lo_we = 1'b0;
    check("mtlo", lo, 32'h55);

    hi_we = 1'b1; wdata = 32'h00001234;
    launch(2'b00, 32'd5, 32'd5);
    hi_we = 1'b0;
    check("we_with_start", hi, 32'h1234);
    wait_done("we_start_res", 32'd0, 32'd25);

    launch(2'b00, 32'hFFFF, 32'hFFFF);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 25);
    seen = 1'b0;
    repeat (30) begin
      tick();
      seen = seen | done;
    end
    check("abort_no_done", seen, 0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_beats_start", busy, 0);

    launch(2'b01, 32'd1000, 32'd1000);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    launch(2'b11, -32'sd100, 32'd7);
    wait_done("recover", 32'hFFFFFFFE, 32'hFFFFFFF2);

    for (int i = 0; i < 24; i++) begin
      op8 = 2'($urandom_range(0, 3));
      a8 = 8'($urandom);
      b8 = (i % 6 == 5) ? 8'd0 : 8'($urandom);
      if (i == 3) begin op8 = 2'b11; a8 = 8'h80; b8 = 8'hFF; end
      e8 = ref8(op8, a8, b8);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      n8 = 0;
      while (!done8 && n8 < 20) begin
        tick();
        n8++;
      end
      check("w8_latency", n8, 9);
      check("w8_result", {hi8, lo8}, e8);
      check("w8_dz", dz8, (op8[1] && b8 == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
